// File: rtl/tbpa_seq_pkg.sv
// Shared types and default timing for the arithmetic-pipeline micro-op sequencer.
package tbpa_seq_pkg;

    localparam int ADDR_W_DEF   = 9;
    localparam int RD_LAT_DEF   = 3;
    localparam int CMUL_OFS_DEF = 14;
    localparam int POST_OFS_DEF = 16;
    localparam int WB_OFS_DEF   = 22;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Everything a downstream stage needs once the RAM addresses have been issued.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] dst;
        logic [2:0]            mode1;
        logic [2:0]            mode2;
        logic [2:0]            cmode;
        logic [2:0]            mode3;
        logic [1:0]            outsel;
        logic [1:0]            addr2;
        logic [1:0]            addr3;
    } op_t;

endpackage

// File: rtl/tbpa_pipe_sequencer_delay_line.sv
// Fixed-latency shift register of {valid, op}; stage k holds the op issued k cycles ago.
module tbpa_op_delay_line
    import tbpa_seq_pkg::*;
#(
    parameter int DEPTH = WB_OFS_DEF + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  op_t              in_op,
    output logic [DEPTH-1:0] stage_valid,
    output op_t              stage_op [DEPTH]
);

    logic [DEPTH-1:0] valid_q, valid_d;
    op_t              op_q [DEPTH];
    op_t              op_d [DEPTH];

    always_comb begin
        valid_d = {valid_q[DEPTH-2:0], in_valid};
        op_d[0] = in_op;
        for (int i = 1; i < DEPTH; i++) begin
            op_d[i] = op_q[i-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples its predecessor's old value.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // NOTE: payload is not reset; every consumer qualifies it with the matching valid bit.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            op_q[i] <= op_d[i];
        end
    end

    assign stage_valid = valid_q;
    assign stage_op    = op_q;

endmodule

// File: rtl/tbpa_pipe_sequencer.sv
// Micro-op sequencer: issues RAM reads, times mode fields to each stage, writes results back.
// Optional build macro TBPA_SEQ_PERF_CNT_EN adds saturating issue/stall counters.
module tbpa_pipe_sequencer
    import tbpa_seq_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int RD_LAT   = RD_LAT_DEF,
    parameter int CMUL_OFS = CMUL_OFS_DEF,
    parameter int POST_OFS = POST_OFS_DEF,
    parameter int WB_OFS   = WB_OFS_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [ADDR_W-1:0] op_src0,
    input  logic [ADDR_W-1:0] op_src1,
    input  logic [ADDR_W-1:0] op_dst,
    input  logic [2:0]        op_mode1,
    input  logic [2:0]        op_mode2,
    input  logic [2:0]        op_cmode,
    input  logic [2:0]        op_mode3,
    input  logic [1:0]        op_outsel,
    input  logic [1:0]        op_addr2,
    input  logic [1:0]        op_addr3,
    input  logic              op_last,
    output logic [ADDR_W-1:0] raddr0,
    output logic [ADDR_W-1:0] raddr1,
    output logic [2:0]        pre_mode1,
    output logic [2:0]        pre_mode2,
    output logic [2:0]        cmul_mode,
    output logic              post_rstn,
    output logic [2:0]        post_mode1,
    output logic [2:0]        post_mode2,
    output logic [2:0]        post_mode3,
    output logic [1:0]        post_outsel,
    output logic [1:0]        post_addr2,
    output logic [1:0]        post_addr3,
    output logic [ADDR_W-1:0] waddr,
    output logic              wea,
    output logic              busy,
    output logic              done
`ifdef TBPA_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]       perf_issue,
    output logic [31:0]       perf_stall
`endif
);

    localparam int DEPTH = WB_OFS + 1;

    if (ADDR_W != ADDR_W_DEF || !(WB_OFS > POST_OFS && POST_OFS > CMUL_OFS && CMUL_OFS > RD_LAT))
    begin : g_bad_cfg
        $error("tbpa_pipe_sequencer: unsupported ADDR_W or offset ordering");
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] raddr0_q, raddr0_d, raddr1_q, raddr1_d;
    logic              hazard, accept;
    logic [DEPTH-1:0]  stage_valid;
    op_t               stage_op [DEPTH];
    op_t               in_op;

    assign in_op = '{dst: op_dst, mode1: op_mode1, mode2: op_mode2, cmode: op_cmode,
                     mode3: op_mode3, outsel: op_outsel, addr2: op_addr2, addr3: op_addr3};
    assign accept = op_valid && op_ready;

    tbpa_op_delay_line #(.DEPTH(DEPTH)) u_delay_line (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (accept),
        .in_op       (in_op),
        .stage_valid (stage_valid),
        .stage_op    (stage_op)
    );

    // Stall while either source matches any in-flight destination, including the one writing now.
    always_comb begin
        // NOTE: default first so no path through the loop leaves hazard unassigned (no latch).
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (stage_valid[i] && (stage_op[i].dst == op_src0 || stage_op[i].dst == op_src1)) begin
                hazard = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            raddr0_q <= '0;
            raddr1_q <= '0;
        end else begin
            state_q  <= state_d;
            raddr0_q <= raddr0_d;
            raddr1_q <= raddr1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (accept && op_last) state_d = ST_DRAIN;
            ST_DRAIN: if (stage_valid == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_ready = (state_q == ST_RUN) && !hazard;
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_DONE);
    end

    always_comb begin
        raddr0_d = accept ? op_src0 : raddr0_q;
        raddr1_d = accept ? op_src1 : raddr1_q;
    end

    assign raddr0 = raddr0_q;
    assign raddr1 = raddr1_q;

    always_comb begin
        pre_mode1   = '0;
        pre_mode2   = '0;
        cmul_mode   = '0;
        post_mode1  = '0;
        post_mode2  = '0;
        post_mode3  = '0;
        post_outsel = '0;
        post_addr2  = '0;
        post_addr3  = '0;
        waddr       = '0;
        post_rstn   = stage_valid[POST_OFS];
        wea         = stage_valid[WB_OFS];
        if (stage_valid[RD_LAT]) begin
            pre_mode1 = stage_op[RD_LAT].mode1;
            pre_mode2 = stage_op[RD_LAT].mode2;
        end
        if (stage_valid[CMUL_OFS]) begin
            cmul_mode = stage_op[CMUL_OFS].cmode;
        end
        if (stage_valid[POST_OFS]) begin
            post_mode1  = stage_op[POST_OFS].mode1;
            post_mode2  = stage_op[POST_OFS].mode2;
            post_mode3  = stage_op[POST_OFS].mode3;
            post_outsel = stage_op[POST_OFS].outsel;
            post_addr2  = stage_op[POST_OFS].addr2;
            post_addr3  = stage_op[POST_OFS].addr3;
        end
        if (stage_valid[WB_OFS]) begin
            waddr = stage_op[WB_OFS].dst;
        end
    end

`ifdef TBPA_SEQ_PERF_CNT_EN
    logic [31:0] perf_issue_q, perf_issue_d, perf_stall_q, perf_stall_d;

    always_comb begin
        perf_issue_d = perf_issue_q;
        perf_stall_d = perf_stall_q;
        if (start && state_q == ST_IDLE) begin
            perf_issue_d = '0;
            perf_stall_d = '0;
        end else begin
            if (accept && perf_issue_q != '1) perf_issue_d = perf_issue_q + 32'd1;
            if (state_q == ST_RUN && op_valid && hazard && perf_stall_q != '1)
                perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_issue_q <= perf_issue_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_issue = perf_issue_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_tbpa_pipe_sequencer.sv
// Directed bench for tbpa_pipe_sequencer: timing of taps, throughput, RAW stall, reset, start filtering.
module tb_tbpa_pipe_sequencer;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rstn, start, op_valid, op_ready, op_last;
    logic [AW-1:0] op_src0, op_src1, op_dst;
    logic [2:0]    op_mode1, op_mode2, op_cmode, op_mode3;
    logic [1:0]    op_outsel, op_addr2, op_addr3;
    logic [AW-1:0] raddr0, raddr1, waddr;
    logic [2:0]    pre_mode1, pre_mode2, cmul_mode, post_mode1, post_mode2, post_mode3;
    logic          post_rstn, wea, busy, done;
    logic [1:0]    post_outsel, post_addr2, post_addr3;
`ifdef TBPA_SEQ_PERF_CNT_EN
    logic [31:0]   perf_issue, perf_stall;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tbpa_pipe_sequencer dut (
        .clk(clk), .rstn(rstn), .start(start), .op_valid(op_valid), .op_ready(op_ready),
        .op_src0(op_src0), .op_src1(op_src1), .op_dst(op_dst),
        .op_mode1(op_mode1), .op_mode2(op_mode2), .op_cmode(op_cmode), .op_mode3(op_mode3),
        .op_outsel(op_outsel), .op_addr2(op_addr2), .op_addr3(op_addr3), .op_last(op_last),
        .raddr0(raddr0), .raddr1(raddr1), .pre_mode1(pre_mode1), .pre_mode2(pre_mode2),
        .cmul_mode(cmul_mode), .post_rstn(post_rstn), .post_mode1(post_mode1),
        .post_mode2(post_mode2), .post_mode3(post_mode3), .post_outsel(post_outsel),
        .post_addr2(post_addr2), .post_addr3(post_addr3), .waddr(waddr), .wea(wea),
        .busy(busy), .done(done)
`ifdef TBPA_SEQ_PERF_CNT_EN
        , .perf_issue(perf_issue), .perf_stall(perf_stall)
`endif
    );

    function automatic logic [63:0] all_outs();
        return {8'd0, raddr0, raddr1, pre_mode1, pre_mode2, cmul_mode, post_rstn, post_mode1,
                post_mode2, post_mode3, post_outsel, post_addr2, post_addr3, waddr, wea,
                busy, done, op_ready};
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        start = 0; op_valid = 0; op_last = 0;
        op_src0 = '0; op_src1 = '0; op_dst = '0;
        op_mode1 = '0; op_mode2 = '0; op_cmode = '0; op_mode3 = '0;
        op_outsel = '0; op_addr2 = '0; op_addr3 = '0;
    endtask

    task automatic drive_op(input int s0, input int s1, input int d, input logic last);
        op_valid = 1; op_src0 = AW'(s0); op_src1 = AW'(s1); op_dst = AW'(d); op_last = last;
    endtask

    task automatic do_reset();
        rstn = 0;
        clear_inputs();
        tick();
        tick();
        rstn = 1;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        total++;
        if (all_outs() !== 64'd0) begin
            bad++; $display("FAIL reset_outs got=%h exp=0", all_outs());
        end
    endtask

    task automatic test_single();
        do_reset();
        tick(); start = 1;
        tick(); start = 0;
        tick();
        drive_op(5, 7, 9, 1'b1);
        op_mode1 = 3; op_cmode = 5; op_mode3 = 6; op_outsel = 2;
        settle();
        total++;
        if (op_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b exp=1", op_ready); end
        tick(); clear_inputs();
        settle();
        total++;
        if (raddr0 !== 9'd5 || raddr1 !== 9'd7) begin
            bad++; $display("FAIL single_raddr got=%0d/%0d exp=5/7", raddr0, raddr1);
        end
        for (int k = 1; k <= 26; k++) begin
            tick(); settle();
            total++;
            if (wea !== (k == 22)) begin bad++; $display("FAIL single_wea k=%0d got=%b", k, wea); end
            total++;
            if (done !== (k == 24)) begin bad++; $display("FAIL single_done k=%0d got=%b", k, done); end
            if (k == 2 || k == 3) begin
                total++;
                if (pre_mode1 !== ((k == 3) ? 3'd3 : 3'd0)) begin
                    bad++; $display("FAIL single_pre_mode1 k=%0d got=%0d", k, pre_mode1);
                end
            end
            if (k == 5) begin
                total++;
                if (raddr0 !== 9'd5) begin bad++; $display("FAIL single_raddr_hold got=%0d exp=5", raddr0); end
            end
            if (k == 14) begin
                total++;
                if (cmul_mode !== 3'd5) begin bad++; $display("FAIL single_cmul got=%0d exp=5", cmul_mode); end
            end
            if (k == 15 || k == 16) begin
                total++;
                if (post_rstn !== (k == 16)) begin bad++; $display("FAIL single_post_rstn k=%0d got=%b", k, post_rstn); end
            end
            if (k == 16) begin
                total++;
                if ({post_mode1, post_mode3, post_outsel} !== {3'd3, 3'd6, 2'd2}) begin
                    bad++; $display("FAIL single_post got=%0d/%0d/%0d exp=3/6/2", post_mode1, post_mode3, post_outsel);
                end
            end
            if (k == 22) begin
                total++;
                if (waddr !== 9'd9) begin bad++; $display("FAIL single_waddr got=%0d exp=9", waddr); end
            end
            if (k == 25) begin
                total++;
                if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b exp=0", busy); end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        tick(); start = 1;
        tick(); start = 0;
        // op i uses src0 == dst, which must not stall on itself
        for (int i = 0; i < 4; i++) begin
            tick();
            drive_op(10 + i, 200 + i, 10 + i, i == 3);
            settle();
            total++;
            if (op_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready op=%0d got=%b exp=1", i, op_ready); end
        end
        tick(); clear_inputs();
        for (int k = 4; k <= 28; k++) begin
            tick(); settle();
            total++;
            if (wea !== (k >= 22 && k <= 25)) begin bad++; $display("FAIL b2b_wea k=%0d got=%b", k, wea); end
            if (k >= 22 && k <= 25) begin
                total++;
                if (waddr !== AW'(k - 12)) begin
                    bad++; $display("FAIL b2b_waddr k=%0d got=%0d exp=%0d", k, waddr, k - 12);
                end
            end
            total++;
            if (done !== (k == 27)) begin bad++; $display("FAIL b2b_done k=%0d got=%b", k, done); end
        end
    endtask

    task automatic test_raw();
        int acc_k;
        int seen_done;
        do_reset();
        tick(); start = 1;
        tick(); start = 0;
        tick();
        drive_op(1, 2, 20, 1'b0);
        settle();
        total++;
        if (op_ready !== 1'b1) begin bad++; $display("FAIL raw_a_ready got=%b exp=1", op_ready); end
        tick();
        drive_op(3, 20, 21, 1'b1);
        settle();
        acc_k = -1;
        for (int k = 0; k < 40 && acc_k < 0; k++) begin
            if (k == 22) begin
                total++;
                if (wea !== 1'b1 || waddr !== 9'd20) begin
                    bad++; $display("FAIL raw_a_write got=%b/%0d exp=1/20", wea, waddr);
                end
            end
            if (op_ready === 1'b1) acc_k = k;
            else begin tick(); settle(); end
        end
        total++;
        if (acc_k != 23) begin bad++; $display("FAIL raw_accept_cycle got=%0d exp=23", acc_k); end
        tick(); clear_inputs();
        settle();
        total++;
        if (raddr0 !== 9'd3 || raddr1 !== 9'd20) begin
            bad++; $display("FAIL raw_b_raddr got=%0d/%0d exp=3/20", raddr0, raddr1);
        end
        seen_done = 0;
        for (int k = 0; k < 30 && seen_done == 0; k++) begin
            tick(); settle();
            if (done === 1'b1) seen_done = 1;
        end
        total++;
        if (seen_done != 1) begin bad++; $display("FAIL raw_done got=none exp=pulse"); end
`ifdef TBPA_SEQ_PERF_CNT_EN
        total++;
        if (perf_issue !== 32'd2) begin bad++; $display("FAIL perf_issue got=%0d exp=2", perf_issue); end
        total++;
        if (perf_stall !== 32'd23) begin bad++; $display("FAIL perf_stall got=%0d exp=23", perf_stall); end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(); start = 1;
        tick(); start = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            drive_op(30 + i, 40 + i, 50 + i, 1'b0);
        end
        tick(); clear_inputs();          // first op's issue cycle + 2
        repeat (8) tick();               // issue + 10
        rstn = 0;
        tick();
        rstn = 1;
        settle();
        total++;
        if (all_outs() !== 64'd0) begin bad++; $display("FAIL midreset_outs got=%h exp=0", all_outs()); end
        for (int k = 0; k < 30; k++) begin
            tick(); settle();
            total++;
            if (wea !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL midreset_quiet k=%0d wea=%b busy=%b exp=0/0", k, wea, busy);
            end
        end
    endtask

    task automatic test_start_ignored();
        int done_cnt;
        do_reset();
        tick(); start = 1;
        tick(); start = 0;
        tick();
        drive_op(60, 61, 62, 1'b0);
        start = 1;
        settle();
        total++;
        if (op_ready !== 1'b1) begin bad++; $display("FAIL start_ign_ready got=%b exp=1", op_ready); end
        tick();
        start = 0;
        drive_op(63, 64, 65, 1'b1);
        tick(); clear_inputs();
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick(); settle();
            if (done === 1'b1) done_cnt++;
        end
        total++;
        if (done_cnt != 1) begin bad++; $display("FAIL start_ign_done got=%0d exp=1", done_cnt); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL start_ign_busy got=%b exp=0", busy); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 0;
        clear_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_raw();
        test_reset_mid();
        test_start_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
